// File: rtl/switch_pkg.sv
// Shared types and defaults for the switch input path: debouncer FSM states and
// the default qualification / diagnostic widths, also used by the switch block bench.
package switch_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int unsigned SW_STABLE_CYCLES = 16;
  localparam int unsigned SW_CNT_W         = 8;
  localparam int unsigned SW_GLITCH_W      = 8;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous level, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      q      <= 1'b0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the raw switch pad into a clean level x with one-cycle edge pulses,
// and keeps a saturating count of aborted transitions for diagnostics.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES,
  parameter int unsigned CNT_W         = SW_CNT_W,
  parameter int unsigned GLITCH_W      = SW_GLITCH_W
) (
  input  logic                clk_1,
  input  logic                rst,
  input  logic                sw_raw,
  output logic                x,
  output logic                x_rise,
  output logic                x_fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic [1:0]          dbg_state,
  output logic [CNT_W-1:0]    dbg_cnt
);

  localparam logic [CNT_W-1:0]    LP_CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] LP_GLITCH_MAX = '1;

  logic             w_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  sync_2ff u_sync (
    .clk   (clk_1),
    .rst_n (rst),
    .d     (sw_raw),
    .q     (w_s2)
  );

  // cnt holds the number of consecutive departing samples seen so far; the
  // transition commits on the sample that would make it STABLE_CYCLES.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_state    <= LOW;
      r_cnt      <= '0;
      x          <= 1'b0;
      x_rise     <= 1'b0;
      x_fall     <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      x_rise <= 1'b0;
      x_fall <= 1'b0;
      case (r_state)
        LOW: begin
          if (w_s2) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!w_s2) begin
            r_state <= LOW;
            r_cnt   <= '0;
            if (glitch_cnt != LP_GLITCH_MAX) glitch_cnt <= glitch_cnt + 1'b1;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= HIGH;
            r_cnt   <= '0;
            x       <= 1'b1;
            x_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!w_s2) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (w_s2) begin
            r_state <= HIGH;
            r_cnt   <= '0;
            if (glitch_cnt != LP_GLITCH_MAX) glitch_cnt <= glitch_cnt + 1'b1;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state <= LOW;
            r_cnt   <= '0;
            x       <= 1'b0;
            x_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy      = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);
  assign dbg_state = r_state;
  assign dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer against a run-length reference model.
module tb_switch_debouncer;

  localparam int S  = 4;
  localparam int GW = 8;
  localparam int CW = 8;
  localparam int GMAX = (1 << GW) - 1;

  logic          clk_1 = 1'b0;
  logic          rst = 1'b0;
  logic          sw_raw = 1'b0;
  logic          x, x_rise, x_fall, busy;
  logic [GW-1:0] glitch_cnt;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_rise = 0;
  int n_fall = 0;

  // reference model: sync pipeline plus "run" = consecutive samples differing from x
  logic m_s1, m_s2, m_x, m_rise, m_fall;
  int   m_run, m_glitch;

  switch_debouncer #(
    .STABLE_CYCLES (S),
    .CNT_W         (CW),
    .GLITCH_W      (GW)
  ) dut (
    .clk_1      (clk_1),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .x          (x),
    .x_rise     (x_rise),
    .x_fall     (x_fall),
    .busy       (busy),
    .glitch_cnt (glitch_cnt),
    .dbg_state  (dbg_state),
    .dbg_cnt    (dbg_cnt)
  );

  always #5 clk_1 = ~clk_1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_x = 0; m_rise = 0; m_fall = 0;
    m_run = 0; m_glitch = 0;
  endtask

  task automatic model_edge(input logic v);
    logic seen;
    seen   = m_s2;
    m_s2   = m_s1;
    m_s1   = v;
    m_rise = 0;
    m_fall = 0;
    if (seen != m_x) begin
      m_run++;
      if (m_run == S) begin
        m_x = seen;
        if (seen) m_rise = 1; else m_fall = 1;
        m_run = 0;
      end
    end else begin
      if (m_run > 0 && m_glitch < GMAX) m_glitch++;
      m_run = 0;
    end
  endtask

  task automatic step(input logic v);
    sw_raw = v;
    @(posedge clk_1);
    model_edge(v);
    #1;
    check_eq("x", x, m_x);
    check_eq("x_rise", x_rise, m_rise);
    check_eq("x_fall", x_fall, m_fall);
    check_eq("busy", busy, (m_run > 0) ? 1 : 0);
    check_eq("glitch_cnt", glitch_cnt, m_glitch);
    check_eq("cnt", dbg_cnt, m_run);
    if (x_rise) n_rise++;
    if (x_fall) n_fall++;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  // asserts reset off-edge, checks the immediate clear, then releases at a falling edge
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_eq("rst_x", x, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cnt", dbg_cnt, 0);
    check_eq("rst_glitch", glitch_cnt, 0);
    check_eq("rst_pulses", {x_rise, x_fall}, 0);
    check_eq("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk_1);
    @(negedge clk_1);
    rst = 1'b1;
    model_reset();
  endtask

  // drives v for 10 edges, expects the single edge pulse after the 6th edge
  task automatic qualify(input logic v, input string tag);
    int first;
    int r0, f0;
    first = 0;
    r0 = n_rise;
    f0 = n_fall;
    for (int i = 1; i <= 10; i++) begin
      step(v);
      if (first == 0 && (v ? x_rise : x_fall)) first = i;
    end
    check_eq({tag, "_latency"}, first, S + 2);
    check_eq({tag, "_rise_count"}, n_rise - r0, v ? 1 : 0);
    check_eq({tag, "_fall_count"}, n_fall - f0, v ? 0 : 1);
    check_eq({tag, "_level"}, x, v);
  endtask

  initial begin
    model_reset();
    @(posedge clk_1);
    do_reset();

    // clean press, then release
    hold(1'b0, 3);
    qualify(1'b1, "press");
    check_eq("press_glitch", glitch_cnt, 0);
    qualify(1'b0, "release");

    // bounce: 2 high, 1 low, 1 high, 1 low, then held high
    do_reset();
    hold(1'b0, 2);
    hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
    qualify(1'b1, "bounce");
    check_eq("bounce_glitch", glitch_cnt, 2);

    // short pulse of S-1 cycles from a stable low
    hold(1'b0, 8);
    hold(1'b1, S - 1);
    hold(1'b0, 8);
    check_eq("short_x", x, 0);
    check_eq("short_busy", busy, 0);
    check_eq("short_glitch", glitch_cnt, 3);

    // reset while qualifying a press at cnt=2
    hold(1'b1, 4);
    check_eq("midwait_cnt", dbg_cnt, 2);
    check_eq("midwait_busy", busy, 1);
    do_reset();
    qualify(1'b1, "post_reset");

    // glitch counter saturation
    do_reset();
    hold(1'b0, 3);
    for (int i = 0; i < 260; i++) begin
      step(1'b1);
      step(1'b0);
    end
    hold(1'b0, 3);
    check_eq("sat_glitch", glitch_cnt, GMAX);
    check_eq("sat_x", x, 0);
    hold(1'b1, 1);
    hold(1'b0, 4);
    check_eq("sat_hold", glitch_cnt, GMAX);

    // random segments of varying length
    do_reset();
    for (int i = 0; i < 200; i++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 2 * S));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the raw mechanical switch input before it reaches the up/down counting switch block, which consumes x.
- Performs 2-flop synchronisation, then stability-count debouncing. Outputs a clean level x plus one-cycle rise/fall pulses.
- Counts rejected bounces for diagnostics.
- Sits directly upstream of the switch block and runs in the clk_1 domain.

Parameters:
- STABLE_CYCLES, default 16: consecutive synchronised samples required before x changes; legal range is 2 or more.
- CNT_W, default 8: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.
- GLITCH_W, default 8: width of the rejected-bounce counter.

Ports:
- clk_1  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserting it low clears all state immediately.
- sw_raw  input  1  raw, asynchronous switch level from the pad.
- x  output  1  debounced switch level, fed to the switch block.
- x_rise  output  1  one-cycle pulse on a debounced 0->1 change.
- x_fall  output  1  one-cycle pulse on a debounced 1->0 change.
- busy  output  1  high while a candidate transition is being qualified.
- glitch_cnt  output  GLITCH_W  saturating count of aborted transitions.

Behaviour:
- Reset (rst low): s1, s2, state=LOW, cnt=0, x=0, x_rise=0, x_fall=0, busy=0, glitch_cnt=0. All take effect asynchronously; reset has priority over everything.
- Synchroniser: s1<=sw_raw and s2<=s1 on every edge. The FSM only ever looks at s2.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. busy = (state==WAIT_HIGH || state==WAIT_LOW), decoded combinationally from the state register.
- In LOW:
  - s2==1 -> WAIT_HIGH with cnt<=1.
  - Otherwise stay in LOW with cnt<=0.
- In WAIT_HIGH:
  - s2==0 -> LOW, cnt<=0, glitch_cnt<=glitch_cnt+1.
  - Else if cnt==STABLE_CYCLES-1 -> HIGH, x<=1, x_rise<=1, cnt<=0.
  - Else cnt<=cnt+1.
- HIGH and WAIT_LOW mirror LOW and WAIT_HIGH with the polarity inverted. A completed release sets x<=0 and x_fall<=1.
- x_rise and x_fall default to 0 on every edge unless set in that edge. Each is high for exactly one clk_1 cycle. They are never high together.
- Latency:
  - sw_raw first sampled high by s1 at edge k and held stable -> x goes high at edge k+STABLE_CYCLES+1.
  - x_rise is high for the cycle following that edge.
  - The same latency applies to the falling direction.
- Minimum accepted width: sw_raw must be sampled stable on STABLE_CYCLES consecutive edges (k..k+STABLE_CYCLES-1). Anything shorter is rejected and increments glitch_cnt by 1.
- Bounces: each return of s2 to the current stable level while in a WAIT state counts as one glitch. The next departure restarts qualification from cnt=1.
- glitch_cnt saturates at 2^GLITCH_W-1 and never wraps. It is cleared only by reset.
- Reset mid-WAIT: the qualification is aborted, x stays 0 and no pulse is produced.
- Reset release with sw_raw held high: this is a normal press. x rises at edge k+STABLE_CYCLES+1 counted from the first sampling edge after release, and x_rise fires.
- cnt never exceeds STABLE_CYCLES-1. No arithmetic wrap is possible given the CNT_W constraint.

Decomposition:
- Package switch_pkg holds:
  - the state enum (LOW, WAIT_HIGH, HIGH, WAIT_LOW), 2 bits;
  - default STABLE_CYCLES and GLITCH_W constants, shared with the switch block's bench.
- One sub-module: sync_2ff. It is a 1-bit two-flop synchroniser with async active-low reset to 0, instantiated once for sw_raw.
- The FSM, stability counter and glitch counter live in the top module.

Test Plan (STABLE_CYCLES=4, GLITCH_W=8):
1. Clean press: rst low for 3 cycles, release with sw_raw=0, then raise sw_raw before edge k and hold -> x=1 from edge k+5; x_rise=1 for one cycle only; busy=1 during edges k+2..k+4; glitch_cnt=0.
2. Bounce: sw_raw high for 2 cycles, low for 1, high for 1, low for 1, then high held -> exactly 2 glitches counted (glitch_cnt=2). x rises 5 edges after the final rise is first sampled; exactly one x_rise pulse.
3. Release: from x=1, drop sw_raw and hold low -> x=0 after STABLE_CYCLES+1 edges; single x_fall pulse; x_rise stays 0.
4. Short pulse: sw_raw high for exactly 3 cycles, then low -> x stays 0, no pulse, glitch_cnt increments by 1, busy returns to 0.
5. Reset mid-WAIT: assert rst low asynchronously while in WAIT_HIGH at cnt=2 -> x, busy, cnt and glitch_cnt read 0 immediately. After release with sw_raw still high -> full 5-edge qualification, then x_rise.
6. Saturation: 260 single-cycle high glitches -> glitch_cnt=255 and holds; x remains 0 throughout.
